// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings, error bit
// indices and the return-stack wrap mode.
// Build option: define PC_STACK_WRAP_EN to make the return stack circular.
// A CALL on a full stack then overwrites the oldest entry and still jumps.
package pc_seq_pkg;

    localparam logic [2:0] PC_NOP       = 3'd0;
    localparam logic [2:0] PC_INC       = 3'd1;
    localparam logic [2:0] PC_JMP_ABS   = 3'd2;
    localparam logic [2:0] PC_JMP_REL   = 3'd3;
    localparam logic [2:0] PC_CALL      = 3'd4;
    localparam logic [2:0] PC_RET       = 3'd5;
    localparam logic [2:0] PC_CLR_STACK = 3'd6;

    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UNF = 1;

`ifdef PC_STACK_WRAP_EN
    localparam bit STACK_WRAP = 1'b1;
`else
    localparam bit STACK_WRAP = 1'b0;
`endif

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The write pointer and the entry count are kept separately.
// In wrap mode the pointer keeps circling when the stack is full, so the oldest
// entry is overwritten while the count stays saturated.
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned DW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, rd_ptr;
    logic [DW-1:0]    depth_q, depth_d;
    logic             push_acc, pop_acc;

    assign full     = (depth_q == DW'(DEPTH));
    assign empty    = (depth_q == '0);
    assign depth    = depth_q;
    assign rd_ptr   = ptr_q - PW'(1);
    assign rd_data  = mem_q[rd_ptr];
    assign push_acc = push && (!full || STACK_WRAP);
    assign pop_acc  = pop && !empty;

    // Next pointer, count and storage; clear has priority over push/pop.
    always_comb begin
        ptr_d   = ptr_q;
        depth_d = depth_q;
        mem_d   = mem_q;
        if (clear) begin
            ptr_d   = '0;
            depth_d = '0;
        end else if (push_acc) begin
            mem_d[ptr_q] = wr_data;
            ptr_d        = ptr_q + PW'(1);
            if (!full) begin
                depth_d = depth_q + DW'(1);
            end
        end else if (pop_acc) begin
            ptr_d   = rd_ptr;
            depth_d = depth_q - DW'(1);
        end
    end

    // Pointer and count registers, synchronously reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            depth_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
        end
    end

    // Entry storage is not reset; contents are meaningless until pushed.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter successor with conditional absolute/relative jumps and
// CALL/RET through an internal return-address stack.
// Build option: PC_STACK_WRAP_EN (see pc_seq_pkg) selects the circular stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REL_W       = 8,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           pc_en,
    input  logic [2:0]                     pc_op,
    input  logic                           cond_ok,
    input  logic [ADDR_W-1:0]              abs_target,
    input  logic [REL_W-1:0]               rel_offset,
    output logic [ADDR_W-1:0]              pc_out,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth,
    output logic                           stack_full,
    output logic                           stack_empty,
    output logic [1:0]                     stack_err
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_next, rel_ext, st_rd;
    logic [1:0]        err_q, err_d;
    logic              st_push, st_pop, st_clr;

    assign pc_next   = pc_q + ADDR_W'(1);
    // Size cast of a signed operand sign-extends the offset.
    assign rel_ext   = ADDR_W'($signed(rel_offset));
    assign pc_out    = pc_q;
    assign stack_err = err_q;

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clock   (clock),
        .reset   (reset),
        .push    (st_push),
        .pop     (st_pop),
        .clear   (st_clr),
        .wr_data (pc_next),
        .rd_data (st_rd),
        .depth   (stack_depth),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    // Decode the op into next PC, stack controls and error updates.
    always_comb begin
        pc_d    = pc_q;
        err_d   = err_q;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_clr  = 1'b0;
        if (pc_en) begin
            case (pc_op)
                PC_INC:     pc_d = pc_next;
                PC_JMP_ABS: pc_d = cond_ok ? abs_target : pc_next;
                PC_JMP_REL: pc_d = cond_ok ? (pc_next + rel_ext) : pc_next;
                PC_CALL: begin
                    if (stack_full && !STACK_WRAP) begin
                        pc_d           = pc_next;
                        err_d[ERR_OVF] = 1'b1;
                    end else begin
                        st_push = 1'b1;
                        pc_d    = abs_target;
                    end
                end
                PC_RET: begin
                    if (stack_empty) begin
                        pc_d           = pc_next;
                        err_d[ERR_UNF] = 1'b1;
                    end else begin
                        st_pop = 1'b1;
                        pc_d   = st_rd;
                    end
                end
                PC_CLR_STACK: begin
                    st_clr = 1'b1;
                    err_d  = 2'b00;
                    pc_d   = pc_next;
                end
                default: pc_d = pc_q;  // NOP and reserved code hold
            endcase
        end
    end

    // PC and sticky error registers; reset overrides any op.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= '0;
            err_q <= 2'b00;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

endmodule
